// File: rtl/adc_sched_pkg.sv
// Shared types and default parameters for the ADC sample scheduler.
// Imported by the scheduler top and its tick generator.
package adc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        WAIT_DONE,
        STORE
    } state_t;

    localparam int N_DEF        = 10;
    localparam int CHANNELS_DEF = 2;
    localparam int DIV_DEF      = 1042;
    localparam int TIMEOUT_DEF  = 512;

    // Channel index width; a single channel still needs one bit.
    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period timer: counts 0..DIV-1 while enabled and flags the last count.
// Held at zero while disabled so a fresh enable always waits a full period.
module sample_tick_gen
    import adc_sched_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic srst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_end;

    assign at_end = (cnt_q == CW'(DIV - 1));
    assign tick   = enable && at_end;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!enable || at_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Round-robin ADC conversion scheduler: one request per channel per sample tick,
// latches results per channel and reports frame completion, overruns and timeouts.
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int CHAN_N   = chan_w(CHANNELS),
    parameter int DIV      = DIV_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                         CLK50,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clr_status,
    output logic                         conv_start,
    output logic [CHAN_N-1:0]            conv_chan,
    input  logic                         conv_done,
    input  logic [N-1:0]                 conv_data,
    output logic [CHANNELS-1:0][N-1:0]   ch_data,
    output logic [CHANNELS-1:0]          ch_valid,
    output logic                         frame_valid,
    output logic                         overrun,
    output logic                         timeout
);

    localparam int WW = $clog2(TIMEOUT + 1);

    logic tick;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (CLK50),
        .srst   (reset),
        .enable (enable),
        .tick   (tick)
    );

    state_t                        state_q, state_d;
    logic [CHAN_N-1:0]             ch_idx_q, ch_idx_d;
    logic [WW-1:0]                 wait_cnt_q, wait_cnt_d;
    logic                          conv_start_q, conv_start_d;
    logic [CHANNELS-1:0][N-1:0]    ch_data_q, ch_data_d;
    logic [CHANNELS-1:0]           ch_valid_q, ch_valid_d;
    logic                          frame_valid_q, frame_valid_d;
    logic                          overrun_q, overrun_d;
    logic                          timeout_q, timeout_d;
    logic                          last_chan;
    logic                          advance;

    assign last_chan = (ch_idx_q == CHAN_N'(CHANNELS - 1));

    always_comb begin
        state_d       = state_q;
        ch_idx_d      = ch_idx_q;
        wait_cnt_d    = wait_cnt_q;
        conv_start_d  = 1'b0;
        ch_data_d     = ch_data_q;
        ch_valid_d    = '0;
        frame_valid_d = 1'b0;
        overrun_d     = overrun_q & ~clr_status;
        timeout_d     = timeout_q & ~clr_status;
        advance       = 1'b0;

        // A tick mid-frame is dropped; the next frame waits for the following tick.
        if (tick && (state_q != IDLE) && (state_q != WAIT_TICK)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    state_d      = START;
                    ch_idx_d     = '0;
                    conv_start_d = 1'b1;
                    wait_cnt_d   = '0;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d    = WAIT_DONE;
                wait_cnt_d = wait_cnt_q + WW'(1);
            end
            WAIT_DONE: begin
                // The wait count includes the request cycle itself.
                if (conv_done) begin
                    state_d              = STORE;
                    ch_data_d[ch_idx_q]  = conv_data;
                    ch_valid_d[ch_idx_q] = 1'b1;
                    frame_valid_d        = last_chan;
                end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    advance   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            STORE: begin
                advance = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (!last_chan) begin
                ch_idx_d     = ch_idx_q + CHAN_N'(1);
                state_d      = START;
                conv_start_d = 1'b1;
                wait_cnt_d   = '0;
            end else begin
                ch_idx_d = '0;
                state_d  = enable ? WAIT_TICK : IDLE;
                // A stored last channel already raised frame_valid on entry to STORE.
                if (state_q == WAIT_DONE) begin
                    frame_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK50) begin
        if (reset) begin
            state_q       <= IDLE;
            ch_idx_q      <= '0;
            wait_cnt_q    <= '0;
            conv_start_q  <= 1'b0;
            ch_data_q     <= '0;
            ch_valid_q    <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_idx_q      <= ch_idx_d;
            wait_cnt_q    <= wait_cnt_d;
            conv_start_q  <= conv_start_d;
            ch_data_q     <= ch_data_d;
            ch_valid_q    <= ch_valid_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    assign conv_start  = conv_start_q;
    assign conv_chan   = ch_idx_q;
    assign ch_data     = ch_data_q;
    assign ch_valid    = ch_valid_q;
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a fixed-latency SPI engine model.
// Event timings are counted in falling edges from the previous observed event.
module tb_adc_sample_scheduler;

    localparam int N       = 10;
    localparam int CH      = 2;
    localparam int CN      = 1;
    localparam int DIV     = 100;
    localparam int TIMEOUT = 60;

    localparam int SIG_START = 0;
    localparam int SIG_CHV   = 1;
    localparam int SIG_FRAME = 2;
    localparam int SIG_TOUT  = 3;
    localparam int SIG_OVR   = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 clr_status;
    logic                 conv_start;
    logic [CN-1:0]        conv_chan;
    logic                 conv_done;
    logic [N-1:0]         conv_data;
    logic [CH-1:0][N-1:0] ch_data;
    logic [CH-1:0]        ch_valid;
    logic                 frame_valid;
    logic                 overrun;
    logic                 timeout;

    int checks = 0;
    int errors = 0;

    int         lat   = 20;
    bit         mute1 = 1'b0;
    logic [9:0] tab [CH];

    adc_sample_scheduler #(
        .N        (N),
        .CHANNELS (CH),
        .CHAN_N   (CN),
        .DIV      (DIV),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK50       (clk),
        .reset       (reset),
        .enable      (enable),
        .clr_status  (clr_status),
        .conv_start  (conv_start),
        .conv_chan   (conv_chan),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .frame_valid (frame_valid),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit sig_of(input int which);
        case (which)
            SIG_START: return conv_start === 1'b1;
            SIG_CHV:   return ch_valid !== '0;
            SIG_FRAME: return frame_valid === 1'b1;
            SIG_TOUT:  return timeout === 1'b1;
            default:   return overrun === 1'b1;
        endcase
    endfunction

    // Returns the falling-edge count at which the signal is first seen, or -1 on expiry.
    task automatic wait_sig(input int which, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (sig_of(which)) begin
                n = i;
                break;
            end
        end
    endtask

    // Engine model: answers L cycles after the cycle in which conv_start was high.
    initial begin
        int rem;
        bit pend;
        int pch;
        rem       = 0;
        pend      = 1'b0;
        pch       = 0;
        conv_done = 1'b0;
        conv_data = '1;
        forever begin
            @(posedge clk);
            #1;
            conv_done = 1'b0;
            conv_data = '1;
            if (pend) begin
                rem--;
                if (rem == 0) begin
                    pend = 1'b0;
                    if (!(mute1 && pch == 1)) begin
                        conv_done = 1'b1;
                        conv_data = tab[pch];
                    end
                end
            end
            if (conv_start === 1'b1) begin
                pend = 1'b1;
                rem  = lat;
                pch  = int'(conv_chan);
            end
        end
    end

    initial begin
        int n;
        tab[0]     = 10'h1D3;
        tab[1]     = 10'h3F2;
        reset      = 1'b1;
        enable     = 1'b0;
        clr_status = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_conv_start", 32'(conv_start), 0);
        check("rst_conv_chan", 32'(conv_chan), 0);
        check("rst_ch_data", 32'(ch_data), 0);
        check("rst_ch_valid", 32'(ch_valid), 0);
        check("rst_frame_valid", 32'(frame_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_timeout", 32'(timeout), 0);
        reset = 1'b0;
        @(negedge clk);

        // Normal frame: first request one full period after enable.
        enable = 1'b1;
        wait_sig(SIG_START, 200, n);
        check("f0_start_lat", n, 100);
        check("f0_chan0", 32'(conv_chan), 0);
        wait_sig(SIG_CHV, 50, n);
        check("f0_chv0_lat", n, 21);
        check("f0_chv0", 32'(ch_valid), 32'b01);
        check("f0_data0", 32'(ch_data[0]), 32'h1D3);
        check("f0_no_frame", 32'(frame_valid), 0);
        wait_sig(SIG_START, 10, n);
        check("f0_start1_lat", n, 1);
        check("f0_chan1", 32'(conv_chan), 1);
        wait_sig(SIG_CHV, 50, n);
        check("f0_chv1_lat", n, 21);
        check("f0_chv1", 32'(ch_valid), 32'b10);
        check("f0_frame", 32'(frame_valid), 1);
        check("f0_data", 32'(ch_data), {12'h0, 10'h3F2, 10'h1D3});
        check("f0_overrun", 32'(overrun), 0);
        check("f0_timeout", 32'(timeout), 0);
        wait_sig(SIG_START, 200, n);
        check("f1_start_lat", n, 57);

        // Channel 1 never answered.
        mute1  = 1'b1;
        tab[0] = 10'h155;
        wait_sig(SIG_CHV, 50, n);
        check("to_chv0_lat", n, 21);
        check("to_data0", 32'(ch_data[0]), 32'h155);
        wait_sig(SIG_START, 10, n);
        check("to_start1_lat", n, 1);
        check("to_chan1", 32'(conv_chan), 1);
        wait_sig(SIG_TOUT, 100, n);
        check("to_timeout_lat", n, 60);
        check("to_frame", 32'(frame_valid), 1);
        check("to_no_chv", 32'(ch_valid), 0);
        check("to_data1_kept", 32'(ch_data[1]), 32'h3F2);
        mute1      = 1'b0;
        tab[1]     = 10'h2C4;
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check("to_cleared", 32'(timeout), 0);
        wait_sig(SIG_START, 200, n);
        check("f2_start_lat", n, 17);
        wait_sig(SIG_CHV, 50, n);
        check("f2_chv0_lat", n, 21);
        wait_sig(SIG_START, 10, n);
        check("f2_start1_lat", n, 1);
        wait_sig(SIG_CHV, 50, n);
        check("f2_chv1_lat", n, 21);
        check("f2_frame", 32'(frame_valid), 1);
        check("f2_data", 32'(ch_data), {12'h0, 10'h2C4, 10'h155});
        check("f2_timeout", 32'(timeout), 0);

        // Latency just under the timeout makes the frame outlast the period.
        lat = 58;
        wait_sig(SIG_START, 200, n);
        check("ov_start_lat", n, 57);
        wait_sig(SIG_CHV, 100, n);
        check("ov_chv0_lat", n, 59);
        wait_sig(SIG_START, 10, n);
        check("ov_start1_lat", n, 1);
        wait_sig(SIG_OVR, 100, n);
        check("ov_set_lat", n, 40);
        wait_sig(SIG_CHV, 100, n);
        check("ov_chv1_lat", n, 19);
        check("ov_frame", 32'(frame_valid), 1);
        check("ov_timeout", 32'(timeout), 0);
        wait_sig(SIG_START, 200, n);
        check("ov_next_start_lat", n, 81);

        // Clear, then clear again in the very cycle the next overrun fires.
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check("ov_cleared", 32'(overrun), 0);
        repeat (98) @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check("ov_set_wins", 32'(overrun), 1);
        wait_sig(SIG_CHV, 50, n);
        check("ov2_chv1_lat", n, 19);
        check("ov2_frame", 32'(frame_valid), 1);
        lat        = 20;
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check("ov2_cleared", 32'(overrun), 0);

        // Enable dropped mid-frame: frame completes, then nothing more.
        wait_sig(SIG_START, 200, n);
        check("en_start_lat", n, 80);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        wait_sig(SIG_CHV, 50, n);
        check("en_chv0_lat", n, 16);
        wait_sig(SIG_START, 10, n);
        check("en_start1_lat", n, 1);
        check("en_chan1", 32'(conv_chan), 1);
        wait_sig(SIG_CHV, 50, n);
        check("en_chv1_lat", n, 21);
        check("en_frame", 32'(frame_valid), 1);
        wait_sig(SIG_START, 300, n);
        check("en_quiet", n, -1);

        // Reset during a conversion; the late answer must be ignored.
        enable = 1'b1;
        wait_sig(SIG_START, 200, n);
        check("rs_start_lat", n, 100);
        repeat (10) @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rs_ch_data", 32'(ch_data), 0);
        check("rs_overrun", 32'(overrun), 0);
        check("rs_timeout", 32'(timeout), 0);
        check("rs_conv_start", 32'(conv_start), 0);
        wait_sig(SIG_CHV, 40, n);
        check("rs_no_chv", n, -1);
        check("rs_ch_data_after", 32'(ch_data), 0);
        check("rs_frame_after", 32'(frame_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
